dc_video_timing_unit: RTL and testbench
=======================================

# dc_video_timing_unit

Video timing unit (VU) for the display controller. It generates the raster (hsync, vsync, data-enable) for a parameterised video mode. It also drains the image processing unit's pixel stream with a ready/valid handshake and drives registered RGB to the HDMI transmitter. It sits directly downstream of the IPU pixel interface, and its blanking outputs feed the main control logic's `vertical_blanking`/`horizontal_blanking` inputs.

## Interface
Parameters:
- `BITS_PER_PIXEL`, 24, pixel/RGB width
- `CNT_WIDTH`, 12, width of h/v counters; H_TOTAL and V_TOTAL must be ≤ 2^CNT_WIDTH
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync width (cycles)
- `H_BP`, 48, horizontal back porch (cycles)
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync
- `UNDERRUN_COLOR`, 24'h000000, RGB emitted on underrun

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous active-high reset
- `en`  in  1  raster enable
- `pixel_valid`  in  1  IPU pixel valid
- `pixel_ready`  out  1  VU accepts pixel
- `pixel_data`  in  BITS_PER_PIXEL  IPU pixel
- `pixel_border`  in  1  pixel is border (forwarded)
- `vertical_blanking`  out  1  v_cnt ≥ V_ACTIVE
- `horizontal_blanking`  out  1  h_cnt ≥ H_ACTIVE
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  data enable
- `rgb`  out  BITS_PER_PIXEL  pixel to transmitter
- `border`  out  1  registered `pixel_border` qualified by `de`
- `frame_start`  out  1  one-cycle pulse at first active pixel of a frame
- `underrun`  out  1  sticky per-frame underrun flag

## Operation
- FSM has two states.
  - IDLE: counters held at h=0, v=V_ACTIVE; `pixel_ready`=0; outputs at reset values.
  - RUN: counters advance every cycle.
  - IDLE→RUN when `en`=1. RUN→IDLE on `en`=0, effective next cycle (same as reset).
- Define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- h_cnt increments each RUN cycle and wraps H_TOTAL-1→0. v_cnt increments on h wrap and wraps V_TOTAL-1→0.
- Counter start point is (0, V_ACTIVE), i.e. the start of vertical blanking. This gives upstream a full vblank to prefill before the first active line.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- `pixel_ready` = RUN and active, combinational from the counter registers. It is asserted regardless of `pixel_valid`.
- A transfer occurs when `pixel_ready` and `pixel_valid` are both high. The pixel is registered to `rgb`, with `border` = `pixel_border`.
- Underrun: active and `pixel_valid`=0.
  - `rgb`=UNDERRUN_COLOR and `border`=0 for that slot.
  - Set `underrun`. The raster never stalls.
- `underrun` is cleared in the same cycle `frame_start` asserts. An underrun on the first pixel of a frame therefore leaves `underrun`=1 (set wins over clear).
- Blanking outputs are combinational from the counters and aligned with `pixel_ready`.
- Sync windows:
  - hsync is active when h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is active when v_cnt ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
  - Inactive level is ~SYNC_POL.
- Outside the active region: `rgb`=0, `de`=0, `border`=0.

## Timing
- Reset values:
  - `pixel_ready`=0, `de`=0, `rgb`=0, `border`=0, `frame_start`=0, `underrun`=0.
  - `hsync`=`vsync`=~SYNC_POL.
  - `vertical_blanking`=0, `horizontal_blanking`=0 (both forced low while in IDLE/reset).
- Pipeline: one register stage.
  - `de`, `rgb`, `border`, `hsync`, `vsync` and `frame_start` reflect the counter state of the previous cycle.
  - All five video outputs (`de`, `rgb`, `border`, `hsync`, `vsync`) stay mutually aligned.
- Latency: a pixel accepted in cycle N appears on `rgb` with `de`=1 in cycle N+1.
- `frame_start` is high in the cycle `de` is first high for v=0, h=0.
- After `rst` deasserts with `en`=1, first `pixel_ready` occurs (V_TOTAL-V_ACTIVE)·H_TOTAL cycles later.
- Handshake: the VU never holds `pixel_ready` for a pending beat. Upstream must present data in the slot or underrun.
- Reset or `en` drop mid-line: the in-flight registered pixel is discarded and outputs return to reset values next cycle.

## Test plan
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8) and V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6), SYNC_POL=0.
- Reset release, `en`=1, `pixel_valid` held 1: first `pixel_ready` exactly 24 cycles later. `de` pulses are 4 high / 4 low, 3 lines per 48-cycle frame.
- Incrementing pixel data 1,2,3…: `rgb` sequence equals accepted data one cycle later. `frame_start` coincides with `rgb`=1. No `underrun`.
- Sync check: `hsync` low for 2 cycles starting 5 cycles after line start (registered position). `vsync` low for exactly 8 cycles, on v_cnt=4.
- `pixel_valid`=0 on pixel (h=2, v=1): `rgb`=UNDERRUN_COLOR in that slot and `underrun` rises. It stays 1 until the next `frame_start`, then 0.
- `pixel_border`=1 on one accepted pixel: `border`=1 only in that `de` cycle. `border` stays 0 during blanking even if `pixel_border`=1.
- `rst` asserted mid-active line, then released: all outputs at reset values the next cycle. The raster restarts at (0, V_ACTIVE) with first `pixel_ready` 24 cycles after release.

Source files
------------

// File: rtl/dc_video_timing_unit.sv
// Video timing unit: raster generator (hsync/vsync/de) that drains the IPU
// pixel stream in lock-step with the active region and drives registered RGB.
module dc_video_timing_unit #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned CNT_WIDTH      = 12,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter logic        SYNC_POL       = 1'b0,
  parameter logic [BITS_PER_PIXEL-1:0] UNDERRUN_COLOR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_border,
  output logic                      vertical_blanking,
  output logic                      horizontal_blanking,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [BITS_PER_PIXEL-1:0] rgb,
  output logic                      border,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_START = CNT_WIDTH'(V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;
  logic [31:0] h_ext, v_ext;
  logic run, live, h_act, v_act, active, at_origin, hs_win, vs_win;

  // Counter decode; compared in 32 bits so a full 2^CNT_WIDTH total cannot alias.
  always_comb begin
    h_ext     = 32'(h_cnt);
    v_ext     = 32'(v_cnt);
    run       = (state_q == RUN);
    live      = run && en;
    h_act     = (h_ext < H_ACTIVE);
    v_act     = (v_ext < V_ACTIVE);
    active    = run && h_act && v_act;
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    hs_win    = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_win    = (v_ext >= VS_START) && (v_ext < VS_END);
  end

  // Handshake and blanking are taken straight from the counter registers.
  always_comb begin
    pixel_ready         = active;
    horizontal_blanking = run && !h_act;
    vertical_blanking   = run && !v_act;
  end

  // Next-state logic: run while enabled, drop back to idle as soon as en falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Raster counters; parked at the start of vertical blanking when not running.
  always_ff @(posedge clk) begin
    if (rst || !live) begin
      h_cnt <= '0;
      v_cnt <= V_START;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_WIDTH'(1);
    end else begin
      h_cnt <= h_cnt + CNT_WIDTH'(1);
    end
  end

  // Single output stage; any exit from running discards the in-flight pixel.
  always_ff @(posedge clk) begin
    if (rst || !live) begin
      de          <= 1'b0;
      rgb         <= '0;
      border      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      de          <= active;
      rgb         <= !active ? '0 : (pixel_valid ? pixel_data : UNDERRUN_COLOR);
      border      <= active && pixel_valid && pixel_border;
      hsync       <= hs_win ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_win ? SYNC_POL : ~SYNC_POL;
      frame_start <= at_origin;
      if (active && !pixel_valid) underrun <= 1'b1;
      else if (at_origin)         underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dc_video_timing_unit.sv
// Directed bench for dc_video_timing_unit on a tiny 8x6 raster.
module tb_dc_video_timing_unit;

  localparam int unsigned BPP = 24;
  localparam logic [BPP-1:0] UC = 24'hA5A5A5;

  logic           clk = 1'b0;
  logic           rst, en, pixel_valid, pixel_border;
  logic [BPP-1:0] pixel_data;
  logic           pixel_ready, vertical_blanking, horizontal_blanking;
  logic           hsync, vsync, de, border, frame_start, underrun;
  logic [BPP-1:0] rgb;

  int total = 0;
  int bad   = 0;

  // Timeline bookkeeping: t counts cycles since the first running cycle.
  int t;
  int first_ready;
  int hs_low, vs_low, de_cnt;
  logic [BPP-1:0] data_q;
  logic exp_und;
  logic prev_act, prev_valid, prev_border;
  logic [BPP-1:0] prev_data;
  int prev_h, prev_v;

  always #5 clk = ~clk;

  dc_video_timing_unit #(
    .BITS_PER_PIXEL(BPP), .CNT_WIDTH(12),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .UNDERRUN_COLOR(UC)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_data(pixel_data), .pixel_border(pixel_border),
    .vertical_blanking(vertical_blanking), .horizontal_blanking(horizontal_blanking),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .border(border),
    .frame_start(frame_start), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(pixel_ready), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_border"}, 32'(border), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_und"}, 32'(underrun), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_vblank"}, 32'(vertical_blanking), 0);
    chk({tag, "_hblank"}, 32'(horizontal_blanking), 0);
  endtask

  task automatic restart_model();
    t = 0; first_ready = -1; hs_low = 0; vs_low = 0; de_cnt = 0;
    data_q = 24'd1; exp_und = 1'b0;
    prev_act = 1'b0; prev_valid = 1'b0; prev_border = 1'b0; prev_data = '0;
    prev_h = 0; prev_v = 3;
  endtask

  // Runs n cycles from the current timeline point; und_t drops valid on that
  // cycle, brd enables the border stimulus (one active, one blanking slot).
  task automatic run(input int n, input int und_t, input bit brd);
    int h, v;
    logic act, vld, bdr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      h = t % 8;
      v = (t / 8 + 3) % 6;
      act = (h < 4) && (v < 3);
      chk("ready", 32'(pixel_ready), 32'(act));
      chk("hblank", 32'(horizontal_blanking), 32'(h >= 4));
      chk("vblank", 32'(vertical_blanking), 32'(v >= 3));
      chk("de", 32'(de), 32'(prev_act));
      chk("rgb", 32'(rgb), !prev_act ? 0 : (prev_valid ? 32'(prev_data) : 32'(UC)));
      chk("border", 32'(border), 32'(prev_act && prev_valid && prev_border));
      chk("hsync", 32'(hsync), 32'(!(prev_h == 5 || prev_h == 6)));
      chk("vsync", 32'(vsync), 32'(prev_v != 4));
      chk("frame_start", 32'(frame_start), 32'(prev_h == 0 && prev_v == 0));
      chk("underrun", 32'(underrun), 32'(exp_und));
      if (pixel_ready && first_ready < 0) first_ready = t;
      if (t < 48) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (de) de_cnt++;
      end
      vld = (t != und_t);
      bdr = brd && (t == 41 || t == 45);
      pixel_valid  = vld;
      pixel_border = bdr;
      pixel_data   = data_q;
      if (act && !vld) exp_und = 1'b1;
      else if (h == 0 && v == 0) exp_und = 1'b0;
      prev_act = act; prev_valid = vld; prev_border = bdr;
      prev_data = data_q; prev_h = h; prev_v = v;
      if (act && vld) data_q = data_q + 24'd1;
      t++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pixel_valid = 1'b1; pixel_border = 1'b0; pixel_data = '0;
    restart_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");

    // Two frames plus a few active pixels; underrun at (h=2,v=1), border at (h=1,v=2).
    rst = 1'b0;
    run(75, 34, 1'b1);
    chk("first_ready", 32'(first_ready), 24);
    chk("hsync_low_frame", 32'(hs_low), 12);
    chk("vsync_low_frame", 32'(vs_low), 8);
    chk("de_high_frame", 32'(de_cnt), 12);

    // Reset mid-active line: everything back to reset values next cycle.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");

    // Raster restarts at the top of vertical blanking.
    rst = 1'b0;
    restart_model();
    run(27, -1, 1'b0);
    chk("first_ready_after_rst", 32'(first_ready), 24);

    // Enable drop mid-line behaves like reset.
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("endrop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
